// File: rtl/ga_palette_regs.sv
// ---------------------------------------------------------------------------
// ga_palette_regs
//
// Gate-array style palette and control registers. The CPU writes them
// through a decoded I/O strobe. Ink writes go either straight to the active
// palette, or into a shadow copy that a small FSM commits on the next VSYNC
// rise.
//
// Ports
//   CLK_n        in   1     sole clock; all state changes on its rising edge
//   RESET        in   1     synchronous, active-high reset
//   M1_n, A14, A15, IORQ_n, S0, S7
//                in   1     bus decode inputs and write strobe
//   D            in   8     CPU data bus
//   VSYNC        in   1     frame sync, synchronous to CLK_n; triggers commit
//   PEN_IDX      in   IDXW  pixel-path pen index
//   PEN_COL      out  COLW  active palette entry PEN_IDX (combinational)
//   BORDER       out  COLW  border colour
//   MODE         out  2     screen mode
//   HROMEN       out  1     upper ROM disable
//   LROMEN       out  1     lower ROM disable
//   IRQ_RESET    out  1     one-cycle interrupt-counter reset pulse
//   COMMIT_BUSY  out  1     high while the shadow palette is being copied
// ---------------------------------------------------------------------------
module ga_palette_regs #(
   parameter int         PENS       = 16,
   parameter int         COLW       = 5,
   parameter logic [4:0] BORDER_RST = 5'h10
) (
   input  logic                    CLK_n,
   input  logic                    RESET,
   input  logic                    M1_n,
   input  logic                    A14,
   input  logic                    A15,
   input  logic                    IORQ_n,
   input  logic                    S0,
   input  logic                    S7,
   input  logic [7:0]              D,
   input  logic                    VSYNC,
   input  logic [$clog2(PENS)-1:0] PEN_IDX,
   output logic [COLW-1:0]         PEN_COL,
   output logic [COLW-1:0]         BORDER,
   output logic [1:0]              MODE,
   output logic                    HROMEN,
   output logic                    LROMEN,
   output logic                    IRQ_RESET,
   output logic                    COMMIT_BUSY
);

   localparam int                 IDXW     = $clog2(PENS);
   localparam logic [4:0]         PENS5    = 5'(PENS);
   localparam logic [3:0]         IDX_MASK = 4'(PENS - 1);
   localparam logic [IDXW-1:0]    CNT_LAST = IDXW'(PENS - 1);

   typedef logic [COLW-1:0] col_t;
   typedef enum logic {ST_IDLE, ST_COPY} state_t;

   // CPU-visible control state
   logic [4:0] inksel;       // [4] selects border, [3:0] pen number
   logic       autoinc;
   logic       defer;

   // Palette storage
   col_t shadow [PENS];
   col_t active [PENS];

   // Commit machinery
   state_t          state;
   logic [IDXW-1:0] cnt;
   logic            pending;
   logic            vsync_q;

   // Decoded strobes
   logic            sel;
   logic            pen_sel_wr;
   logic            border_wr;
   logic            ink_wr;
   logic            pen_wr;
   logic            ctrl_wr;
   logic            commit_start;
   logic [IDXW-1:0] pen;
   logic [3:0]      ink_next;

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can
      // leave a value held over and infer a latch.
      sel          = 1'b0;
      pen_sel_wr   = 1'b0;
      border_wr    = 1'b0;
      ink_wr       = 1'b0;
      pen_wr       = 1'b0;
      ctrl_wr      = 1'b0;
      commit_start = 1'b0;

      sel = M1_n & A14 & ~A15 & ~IORQ_n & S0 & S7;
      if (sel) begin
         case (D[7:6])
            2'b00:   pen_sel_wr = 1'b1;
            2'b01: begin
               border_wr = inksel[4];
               ink_wr    = ~inksel[4];
            end
            2'b10:   ctrl_wr = 1'b1;
            default: ;  // 2'b11 is not decoded
         endcase
      end

      // Pen numbers at or above PENS are dropped silently, but the write
      // still counts for auto-increment below.
      pen_wr = ink_wr && ({1'b0, inksel[3:0]} < PENS5);

      commit_start = VSYNC & ~vsync_q & pending & (state == ST_IDLE);
   end

   assign pen      = inksel[IDXW-1:0];
   // PENS is a power of two, so masking the 4-bit sum gives the modulo.
   assign ink_next = (inksel[3:0] + 4'd1) & IDX_MASK;

   // CPU control registers
   always_ff @(posedge CLK_n) begin
      // NOTE: sequential state is assigned with <= only, so every block reads
      // the pre-edge values no matter what order the blocks run in.
      if (RESET) begin
         inksel    <= '0;
         autoinc   <= 1'b0;
         defer     <= 1'b0;
         BORDER    <= BORDER_RST[COLW-1:0];
         MODE      <= 2'b00;
         HROMEN    <= 1'b0;
         LROMEN    <= 1'b0;
         IRQ_RESET <= 1'b0;
      end else begin
         IRQ_RESET <= ctrl_wr & D[4];

         if (pen_sel_wr) begin
            inksel  <= D[4:0];
            autoinc <= D[5];
         end else if (ink_wr && autoinc) begin
            inksel[3:0] <= ink_next;
         end

         if (border_wr) begin
            BORDER <= D[COLW-1:0];
         end

         if (ctrl_wr) begin
            defer  <= D[5];
            HROMEN <= D[3];
            LROMEN <= D[2];
            MODE   <= D[1:0];
         end
      end
   end

   // Shadow and active palettes
   always_ff @(posedge CLK_n) begin
      if (RESET) begin
         // NOTE: the palette arrays are cleared on reset because the pixel
         // path must show pen 0 colour, not garbage, right after reset.
         for (int i = 0; i < PENS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         if (state == ST_COPY) begin
            active[cnt] <= shadow[cnt];
         end
         // This comes after the copy, so a direct CPU write to the pen
         // being copied on the same edge takes priority.
         if (pen_wr) begin
            shadow[pen] <= D[COLW-1:0];
            if (!defer) begin
               active[pen] <= D[COLW-1:0];
            end
         end
      end
   end

   // Commit FSM: copies every shadow entry into the active palette, one pen
   // per cycle, after a VSYNC rise that finds a pending deferred write.
   always_ff @(posedge CLK_n) begin
      if (RESET) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         pending <= 1'b0;
         vsync_q <= 1'b0;
      end else begin
         vsync_q <= VSYNC;

         case (state)
            ST_IDLE: begin
               if (commit_start) begin
                  state <= ST_COPY;
                  cnt   <= '0;
               end
            end
            ST_COPY: begin
               cnt <= cnt + IDXW'(1);
               if (cnt == CNT_LAST) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // A deferred write on the start edge must not be lost, so the set
         // outranks the clear.
         if (pen_wr && defer) begin
            pending <= 1'b1;
         end else if (commit_start) begin
            pending <= 1'b0;
         end
      end
   end

   assign COMMIT_BUSY = (state == ST_COPY);
   assign PEN_COL     = active[PEN_IDX];

endmodule
